// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, single-outstanding imem request, IF/ID control
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall_in,
  input  logic        id_redirect,
  input  logic [31:0] id_redirect_pc,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [1:0]  if_id_ctr
);

  localparam logic [1:0] CTR_WRITE  = 2'b00;
  localparam logic [1:0] CTR_HOLD   = 2'b01;
  localparam logic [1:0] CTR_BUBBLE = 2'b10;

  // REQ: request on the bus; WAIT: awaiting a live response;
  // HOLD: response parked while IF/ID is stalled; DROP: awaiting a stale response
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] buf_instr;
  logic [31:0] buf_instr_n;
  logic [31:0] buf_pc;
  logic [31:0] buf_pc_n;

  logic        redirect;
  logic [31:0] target;

  // An ID redirect while stalled belongs to a branch still held in ID, so it waits
  assign redirect = ex_redirect | (id_redirect & ~stall_in);
  assign target   = ex_redirect ? ex_redirect_pc : id_redirect_pc;

  // State, PC and parking buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_REQ;
      pc        <= RESET_PC;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      buf_instr <= buf_instr_n;
      buf_pc    <= buf_pc_n;
    end
  end

  // Next-state, PC update and Mealy outputs toward imem and IF/ID
  always_comb begin
    state_n        = state;
    pc_n           = pc;
    buf_instr_n    = buf_instr;
    buf_pc_n       = buf_pc;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc;
    out_instr      = '0;
    out_pc         = '0;
    if_id_ctr      = CTR_BUBBLE;

    case (state)
      ST_REQ: begin
        if (redirect) begin
          pc_n = target;
        end
        // A request accepted in the same cycle as a redirect is already stale
        if (imem_req_ready) begin
          state_n = redirect ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_n    = target;
          state_n = ST_REQ;
        end else if (imem_resp_valid) begin
          pc_n = pc + 32'd4;
          if (stall_in) begin
            buf_instr_n = imem_resp_data;
            buf_pc_n    = pc;
            state_n     = ST_HOLD;
          end else begin
            state_n = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_n    = target;
          state_n = ST_REQ;
        end else if (!stall_in) begin
          state_n = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          pc_n = target;
        end
        // The stale response ends the drop even if another redirect lands with it
        if (imem_resp_valid) begin
          state_n = ST_REQ;
        end
      end
      default: begin
        state_n = ST_REQ;
      end
    endcase

    if (!rst) begin
      imem_req_valid = (state == ST_REQ);
      case (state)
        ST_WAIT: begin
          out_instr = imem_resp_data;
          out_pc    = pc;
        end
        ST_HOLD: begin
          out_instr = buf_instr;
          out_pc    = buf_pc;
        end
        default: begin
          out_instr = '0;
          out_pc    = '0;
        end
      endcase
      if (redirect) begin
        if_id_ctr = CTR_BUBBLE;
      end else if (stall_in) begin
        if_id_ctr = CTR_HOLD;
      end else if ((state == ST_WAIT && imem_resp_valid) || state == ST_HOLD) begin
        if_id_ctr = CTR_WRITE;
      end else begin
        if_id_ctr = CTR_BUBBLE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a flag/queue reference model
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I2  = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        stall_in = 1'b0;
  logic        id_redirect = 1'b0;
  logic [31:0] id_redirect_pc = '0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_redirect_pc = '0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  if_id_ctr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .stall_in       (stall_in),
    .id_redirect    (id_redirect),
    .id_redirect_pc (id_redirect_pc),
    .ex_redirect    (ex_redirect),
    .ex_redirect_pc (ex_redirect_pc),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .if_id_ctr      (if_id_ctr)
  );

  int checks   = 0;
  int failures = 0;

  // Model: next fetch PC, whether a request is in flight and whether it is stale,
  // and a queue of fetched-but-undelivered instructions
  logic [31:0] m_pc      = RPC;
  bit          m_out     = 1'b0;
  bit          m_stale   = 1'b0;
  logic [31:0] m_req_pc  = '0;
  logic [31:0] m_pend_instr[$];
  logic [31:0] m_pend_pc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          red;
    logic [31:0] tgt;
    red = ex_redirect | (id_redirect & ~stall_in);
    tgt = ex_redirect ? ex_redirect_pc : id_redirect_pc;
    if (rst) begin
      m_pc = RPC; m_out = 0; m_stale = 0;
      m_pend_instr.delete(); m_pend_pc.delete();
    end else if (!m_out && m_pend_pc.size() == 0) begin
      if (imem_req_ready) begin
        m_out = 1; m_stale = red; m_req_pc = m_pc;
      end
      if (red) m_pc = tgt;
    end else if (m_out && m_stale) begin
      if (red) m_pc = tgt;
      if (imem_resp_valid) m_out = 0;
    end else if (m_out) begin
      if (red) begin
        m_pc = tgt; m_out = 0;
      end else if (imem_resp_valid) begin
        m_out = 0;
        m_pc = m_req_pc + 32'd4;
        if (stall_in) begin
          m_pend_instr.push_back(imem_resp_data);
          m_pend_pc.push_back(m_req_pc);
        end
      end
    end else begin
      if (red) begin
        m_pend_instr.delete(); m_pend_pc.delete(); m_pc = tgt;
      end else if (!stall_in) begin
        void'(m_pend_instr.pop_front()); void'(m_pend_pc.pop_front());
      end
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin : compare
    bit          red;
    logic        ev;
    logic [1:0]  ec;
    logic [31:0] ei;
    logic [31:0] ep;
    red = ex_redirect | (id_redirect & ~stall_in);
    if (rst) begin
      ev = 0; ec = 2'b10; ei = '0; ep = '0;
    end else begin
      ev = !m_out && m_pend_pc.size() == 0;
      if (red) ec = 2'b10;
      else if (stall_in) ec = 2'b01;
      else if (m_pend_pc.size() != 0 || (m_out && !m_stale && imem_resp_valid)) ec = 2'b00;
      else ec = 2'b10;
      if (m_pend_pc.size() != 0) begin
        ei = m_pend_instr[0]; ep = m_pend_pc[0];
      end else begin
        ei = imem_resp_data; ep = m_req_pc;
      end
    end
    check("model_req_valid", 32'(imem_req_valid), 32'(ev));
    if (!rst) check("model_req_addr", imem_req_addr, m_pc);
    check("model_ctr", 32'(if_id_ctr), 32'(ec));
    if (rst || ec == 2'b00) begin
      check("model_out_instr", out_instr, ei);
      check("model_out_pc", out_pc, ep);
    end
  end

  task automatic cyc(input bit r, input bit rdy, input bit rv, input logic [31:0] rd,
                     input bit st, input bit idr, input logic [31:0] idpc,
                     input bit exr, input logic [31:0] expc);
    @(posedge clk);
    model_step();
    #1;
    rst = r; imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rd;
    stall_in = st; id_redirect = idr; id_redirect_pc = idpc;
    ex_redirect = exr; ex_redirect_pc = expc;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // reset held
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_valid", 32'(imem_req_valid), 0);
    check("rst_ctr", 32'(if_id_ctr), 32'h2);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc", out_pc, 0);
    // zero-wait stream
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("first_valid", 32'(imem_req_valid), 1);
    check("first_addr", imem_req_addr, 32'h100);
    cyc(0, 0, 1, NOP, 0, 0, 0, 0, 0);
    check("first_ctr", 32'(if_id_ctr), 0);
    check("first_out_pc", out_pc, 32'h100);
    check("first_out_instr", out_instr, NOP);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("second_addr", imem_req_addr, 32'h104);
    // stall for 3 cycles on the 0x104 response
    cyc(0, 0, 1, I2, 1, 0, 0, 0, 0);
    check("stall_ctr0", 32'(if_id_ctr), 1);
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0);
    check("stall_ctr1", 32'(if_id_ctr), 1);
    check("stall_no_req", 32'(imem_req_valid), 0);
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0);
    check("stall_ctr2", 32'(if_id_ctr), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("hold_ctr", 32'(if_id_ctr), 0);
    check("hold_out_pc", out_pc, 32'h104);
    check("hold_out_instr", out_instr, I2);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("after_hold_addr", imem_req_addr, 32'h108);
    // EX redirect in WAIT, late response lands in REQ
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h200);
    check("exr_ctr", 32'(if_id_ctr), 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("exr_addr", imem_req_addr, 32'h200);
    cyc(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    check("late_resp_ctr", 32'(if_id_ctr), 2);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("exr_req_addr", imem_req_addr, 32'h200);
    cyc(0, 0, 1, NOP, 0, 0, 0, 0, 0);
    check("exr_out_pc", out_pc, 32'h200);
    // simultaneous EX and ID redirect: EX wins
    cyc(0, 0, 0, 0, 0, 1, 32'h400, 1, 32'h300);
    check("both_ctr", 32'(if_id_ctr), 2);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("both_addr", imem_req_addr, 32'h300);
    cyc(0, 0, 1, NOP, 0, 0, 0, 0, 0);
    check("both_out_pc", out_pc, 32'h300);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("seq_addr", imem_req_addr, 32'h304);
    // ID redirect ignored while stalled, honoured once released
    cyc(0, 0, 1, NOP, 1, 1, 32'h500, 0, 0);
    check("idr_stall_ctr0", 32'(if_id_ctr), 1);
    cyc(0, 0, 0, 0, 1, 1, 32'h500, 0, 0);
    check("idr_stall_ctr1", 32'(if_id_ctr), 1);
    cyc(0, 0, 0, 0, 0, 1, 32'h500, 0, 0);
    check("idr_ctr", 32'(if_id_ctr), 2);
    // handshake with redirect goes to DROP; redirect inside DROP; stale response ends DROP
    cyc(0, 1, 0, 0, 0, 0, 0, 1, 32'h600);
    check("idr_addr", imem_req_addr, 32'h500);
    cyc(0, 0, 0, 0, 0, 1, 32'h700, 0, 0);
    check("drop_no_req", 32'(imem_req_valid), 0);
    cyc(0, 0, 1, 32'h0000_0BAD, 0, 0, 0, 0, 0);
    check("drop_resp_ctr", 32'(if_id_ctr), 2);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("drop_addr", imem_req_addr, 32'h700);
    // reset during WAIT, stale response after release
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("midrst_valid", 32'(imem_req_valid), 0);
    check("midrst_ctr", 32'(if_id_ctr), 2);
    cyc(0, 0, 1, 32'h0000_0BAD, 0, 0, 0, 0, 0);
    check("postrst_addr", imem_req_addr, RPC);
    check("postrst_ctr", 32'(if_id_ctr), 2);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, NOP, 0, 0, 0, 0, 0);
    check("postrst_out_pc", out_pc, RPC);
    // PC wrap at the top of the address space
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 1, NOP, 0, 0, 0, 0, 0);
    check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    // response and redirect together in DROP
    cyc(0, 1, 0, 0, 0, 0, 0, 1, 32'h800);
    check("wrap_addr", imem_req_addr, 32'h0);
    cyc(0, 0, 1, 32'h0000_0BAD, 0, 0, 0, 1, 32'h900);
    check("drop_redir_ctr", 32'(if_id_ctr), 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("drop_redir_valid", 32'(imem_req_valid), 1);
    check("drop_redir_addr", imem_req_addr, 32'h900);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
